run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_if.sv | 22 ++
 rtl/run_ctrl.sv | 89 ++++++++
 tb/tb_run_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Host/program-counter side of run_ctrl: start/halt inputs and run status outputs.
interface run_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req;
    logic             halt;
    logic             pcInit;
    logic             bgn;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycCnt;

    modport master (
        output req, halt,
        input  pcInit, bgn, ack, timeout, cycCnt
    );

    modport slave (
        input  req, halt,
        output pcInit, bgn, ack, timeout, cycCnt
    );
endinterface

// File: rtl/run_ctrl.sv
// Program run controller: IDLE/LOAD/RUN/DONE sequencer with a per-run cycle
// counter and a forced timeout when the cycle limit is reached without halt.
module run_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_CYC = 32'hFFFF
) (
    input  logic       clk,
    input  logic       init,
    run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Count value on the edge that must end the run if halt has not arrived.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             to_q;
    logic             at_limit;

    assign at_limit = (cnt_q == LAST);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = bus.req ? LOAD : IDLE;
            LOAD:    state_nxt = RUN;
            RUN:     state_nxt = (bus.halt || at_limit) ? DONE : RUN;
            DONE:    state_nxt = bus.req ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pcInit = 1'b1;
        bus.bgn    = 1'b1;
        bus.ack    = 1'b0;
        case (state)
            RUN: begin
                bus.pcInit = 1'b0;
                bus.bgn    = 1'b0;
            end
            DONE: begin
                bus.pcInit = 1'b0;
                bus.ack    = 1'b1;
            end
            default: ;
        endcase
    end

    // Halt takes priority over the limit: timeout only when halt is absent.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    cnt_q <= '0;
                    to_q  <= 1'b0;
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!bus.halt && at_limit) begin
                        to_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cycCnt  = cnt_q;
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Randomized run_ctrl bench; expectations come from a run-level model of halt/limit rules.
module tb_run_ctrl;
    localparam int unsigned CW   = 16;
    localparam int unsigned MAXC = 8;

    logic clk = 1'b0;
    logic init;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] exp_cnt;
    logic          exp_to;

    run_ctrl_if #(.CNT_W(CW)) bus ();

    run_ctrl #(.CNT_W(CW), .MAX_CYC(MAXC)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic pi, input logic b, input logic a);
        check_eq({tag, ".pcInit"}, 32'(bus.pcInit), 32'(pi));
        check_eq({tag, ".bgn"},    32'(bus.bgn),    32'(b));
        check_eq({tag, ".ack"},    32'(bus.ack),    32'(a));
    endtask

    task automatic chk_stat(input string tag);
        check_eq({tag, ".cycCnt"},  32'(bus.cycCnt),  32'(exp_cnt));
        check_eq({tag, ".timeout"}, 32'(bus.timeout), 32'(exp_to));
    endtask

    // Asynchronous reset pulse placed between edges; outputs must settle without a clock.
    task automatic pulse_init(input string tag);
        #1 init = 1'b1;
        #1;
        exp_cnt = '0;
        exp_to  = 1'b0;
        chk_out(tag, 1'b1, 1'b1, 1'b0);
        chk_stat(tag);
        #1 init = 1'b0;
    endtask

    // halt_at: 0 = random halts, 1..MAXC = halt on that RUN edge, >MAXC = never.
    task automatic do_run(input int unsigned halt_at, input bit jitter_req, input bit abort_done);
        int unsigned k;
        bit          h;
        bit          ended;
        int unsigned n;

        bus.req  = 1'b1;
        bus.halt = 1'($urandom_range(0, 1));
        tick;
        chk_out("load", 1'b1, 1'b1, 1'b0);
        chk_stat("load");

        bus.halt = 1'($urandom_range(0, 1));
        tick;
        k = 0;
        h = 1'b0;
        ended = 1'b0;
        while (!ended) begin
            k++;
            chk_out("run", 1'b0, 1'b0, 1'b0);
            check_eq("run.cycCnt",  32'(bus.cycCnt),  k - 1);
            check_eq("run.timeout", 32'(bus.timeout), 32'd0);
            if (halt_at == 0) h = ($urandom_range(0, 5) == 0);
            else              h = (k == halt_at);
            bus.halt = h;
            if (jitter_req) bus.req = 1'($urandom_range(0, 1));
            tick;
            ended = h || (k == MAXC);
        end
        exp_cnt = CW'(k);
        exp_to  = !h;

        bus.req = 1'b1;
        n = $urandom_range(1, 5);
        for (int unsigned i = 0; i < n; i++) begin
            bus.halt = 1'($urandom_range(0, 1));
            chk_out("done", 1'b0, 1'b1, 1'b1);
            chk_stat("done");
            tick;
        end
        chk_out("done.hold", 1'b0, 1'b1, 1'b1);
        chk_stat("done.hold");

        if (abort_done) begin
            pulse_init("abort.done");
            bus.req = 1'b0;
            tick;
        end else begin
            bus.req = 1'b0;
            tick;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            bus.halt = 1'($urandom_range(0, 1));
            chk_out("idle", 1'b1, 1'b1, 1'b0);
            chk_stat("idle");
            tick;
        end
    endtask

    initial begin
        init     = 1'b1;
        bus.req  = 1'b0;
        bus.halt = 1'b0;
        exp_cnt  = '0;
        exp_to   = 1'b0;
        #1;
        chk_out("reset", 1'b1, 1'b1, 1'b0);
        chk_stat("reset");
        #2 init = 1'b0;
        tick;
        chk_out("idle0", 1'b1, 1'b1, 1'b0);

        do_run(4, 1'b0, 1'b0);             // halt on 4th RUN edge
        do_run(MAXC + 1, 1'b0, 1'b0);      // never halt -> timeout
        do_run(MAXC, 1'b0, 1'b0);          // halt ties with the limit
        do_run(3, 1'b1, 1'b0);             // req toggling during RUN
        do_run(MAXC + 1, 1'b1, 1'b1);      // reset while parked in DONE

        // Abort in the 3rd RUN cycle with req left high: restart on first edge.
        bus.req  = 1'b1;
        bus.halt = 1'b0;
        tick;
        tick;
        tick;
        tick;
        chk_out("run3", 1'b0, 1'b0, 1'b0);
        check_eq("run3.cycCnt", 32'(bus.cycCnt), 32'd2);
        pulse_init("abort.run");
        tick;
        chk_out("restart", 1'b1, 1'b1, 1'b0);
        tick;
        chk_out("restart.run", 1'b0, 1'b0, 1'b0);
        check_eq("restart.cycCnt", 32'(bus.cycCnt), 32'd0);
        pulse_init("abort.run2");
        bus.req = 1'b0;
        tick;
        chk_out("idle1", 1'b1, 1'b1, 1'b0);

        for (int unsigned r = 0; r < 25; r++) begin
            do_run(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
